// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the wb_gpio pulse generator.
//   TIMER_COUNTER_WIDTH_DEFAULT : default width of delay/width counts
//   timer_state_e               : generator phases S_IDLE/S_DELAY/S_ACTIVE/S_DONE
package timer_pkg;

  localparam int TIMER_COUNTER_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } timer_state_e;

endpackage

// File: rtl/timer_phase_counter.sv
// timer_phase_counter: prescaler-tick counter shared by the DELAY and ACTIVE
// phases of timer_pulse_gen.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (wins over counting)
//   en         : counting allowed (generator is in a timed phase)
//   tick       : prescaler strobe
//   target     : phase length in ticks (never 0 while en=1)
//   expire     : combinational, high on the tick that completes the phase
module timer_phase_counter
  import timer_pkg::*;
#(
  parameter int TIMER_COUNTER_WIDTH = TIMER_COUNTER_WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           en,
  input  logic                           tick,
  input  logic [TIMER_COUNTER_WIDTH-1:0] target,
  output logic                           expire
);

  localparam logic [TIMER_COUNTER_WIDTH-1:0] ONE = TIMER_COUNTER_WIDTH'(1);

  logic [TIMER_COUNTER_WIDTH-1:0] count;
  logic [TIMER_COUNTER_WIDTH-1:0] last;

  assign last   = target - ONE;
  assign expire = en && tick && (count == last);

  // Saturates at the compare value instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && tick && (count != last)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/timer_pulse_gen.sv
// timer_pulse_gen: programmable one-shot/periodic pulse generator. After an
// accepted start it waits delay_count prescaler ticks, drives pulse_out to
// PULSE_ACTIVE_LEVEL for width_count ticks, then strobes done.
//   clk, rst_n   : clock, synchronous active-low reset
//   ps_tick      : prescaler strobe
//   start, stop  : one-cycle control strobes (stop has priority)
//   repeat_mode  : 1 = periodic, 0 = one-shot (latched on start)
//   delay_count  : ticks before the pulse
//   width_count  : ticks of active pulse
//   pulse_out    : generated pulse (registered)
//   busy         : generator not idle (registered)
//   done         : one-cycle strobe at end of each pulse (registered)
// Build option: define TIMER_PULSE_REPEAT_EN to support periodic operation;
// otherwise repeat_mode is ignored and DONE always returns to IDLE.
module timer_pulse_gen
  import timer_pkg::*;
#(
  parameter int   TIMER_COUNTER_WIDTH = TIMER_COUNTER_WIDTH_DEFAULT,
  parameter logic PULSE_ACTIVE_LEVEL  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ps_tick,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           repeat_mode,
  input  logic [TIMER_COUNTER_WIDTH-1:0] delay_count,
  input  logic [TIMER_COUNTER_WIDTH-1:0] width_count,
  output logic                           pulse_out,
  output logic                           busy,
  output logic                           done
);

  timer_state_e state, state_nxt;

  logic [TIMER_COUNTER_WIDTH-1:0] delay_q;
  logic [TIMER_COUNTER_WIDTH-1:0] width_q;
  logic [TIMER_COUNTER_WIDTH-1:0] cnt_target;
  logic                           cnt_clr;
  logic                           cnt_en;
  logic                           cnt_expire;
  logic                           load;

  // First phase after a start or a periodic restart; zero-length phases are skipped.
  function automatic timer_state_e first_phase(input logic [TIMER_COUNTER_WIDTH-1:0] d,
                                               input logic [TIMER_COUNTER_WIDTH-1:0] w);
    if (d != '0) begin
      return S_DELAY;
    end else if (w != '0) begin
      return S_ACTIVE;
    end else begin
      return S_DONE;
    end
  endfunction

`ifdef TIMER_PULSE_REPEAT_EN
  logic repeat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      repeat_q <= 1'b0;
    end else if (load) begin
      repeat_q <= repeat_mode;
    end
  end
`else
  logic unused_repeat_mode;
  assign unused_repeat_mode = repeat_mode;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_q <= '0;
      width_q <= '0;
    end else if (load) begin
      delay_q <= delay_count;
      width_q <= width_count;
    end
  end

  assign cnt_en     = (state == S_DELAY) || (state == S_ACTIVE);
  assign cnt_target = (state == S_DELAY) ? delay_q : width_q;

  timer_phase_counter #(
    .TIMER_COUNTER_WIDTH(TIMER_COUNTER_WIDTH)
  ) u_phase_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tick   (ps_tick),
    .target (cnt_target),
    .expire (cnt_expire)
  );

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = first_phase(delay_count, width_count);
        end
      end
      S_DELAY: begin
        if (cnt_expire) begin
          cnt_clr   = 1'b1;
          state_nxt = (width_q != '0) ? S_ACTIVE : S_DONE;
        end
      end
      S_ACTIVE: begin
        if (cnt_expire) begin
          cnt_clr   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        cnt_clr = 1'b1;
`ifdef TIMER_PULSE_REPEAT_EN
        state_nxt = repeat_q ? first_phase(delay_q, width_q) : S_IDLE;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    // stop overrides every transition, including a same-cycle start.
    if (stop) begin
      state_nxt = S_IDLE;
      load      = 1'b0;
      cnt_clr   = 1'b1;
    end
  end

  // Outputs decoded from the next state so they change on the entering edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pulse_out <= ~PULSE_ACTIVE_LEVEL;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_out <= (state_nxt == S_ACTIVE) ? PULSE_ACTIVE_LEVEL : ~PULSE_ACTIVE_LEVEL;
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_timer_pulse_gen.sv
// tb_timer_pulse_gen: self-checking bench for timer_pulse_gen. Each scenario
// is a per-cycle table of inputs; the expected outputs are planned from the
// tick schedule (edge of the n-th tick after phase entry) and compared every
// cycle. Honours TIMER_PULSE_REPEAT_EN to predict periodic behaviour.
module tb_timer_pulse_gen;

  localparam int W = 16;
  localparam int H = 160;

`ifdef TIMER_PULSE_REPEAT_EN
  localparam bit REP_BUILT = 1'b1;
`else
  localparam bit REP_BUILT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ps_tick = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         repeat_mode = 1'b0;
  logic [W-1:0] delay_count = '0;
  logic [W-1:0] width_count = '0;
  logic         pulse_out;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  timer_pulse_gen #(
    .TIMER_COUNTER_WIDTH(W),
    .PULSE_ACTIVE_LEVEL (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps_tick    (ps_tick),
    .start      (start),
    .stop       (stop),
    .repeat_mode(repeat_mode),
    .delay_count(delay_count),
    .width_count(width_count),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scenario table: value sampled at edge k; expected outputs just after edge k.
  bit s_tick[H], s_start[H], s_stop[H], s_rst[H], s_rep[H];
  int s_d[H], s_w[H];
  bit e_pulse[H], e_busy[H], e_done[H];

  function automatic int nth_tick_after(input int c, input int n);
    int seen = 0;
    for (int e = c + 1; e < H; e++) begin
      if (s_tick[e]) begin
        seen++;
        if (seen == n) return e;
      end
    end
    return H;
  endfunction

  task automatic clear_scn();
    for (int k = 0; k < H; k++) begin
      s_tick[k] = 1'b0; s_start[k] = 1'b0; s_stop[k] = 1'b0; s_rst[k] = 1'b0;
      s_rep[k]  = 1'($urandom_range(1));
      s_d[k]    = int'($urandom_range(9));
      s_w[k]    = int'($urandom_range(9));
    end
    s_rst[0] = 1'b1;
  endtask

  // Whole operation planned at the accepting edge: delay ends on the d-th
  // tick after entry, pulse ends on the w-th tick after that; a periodic
  // restart behaves like a fresh start one clock after DONE.
  task automatic plan(input int s, input int d, input int w, input bit rep);
    int c, a, dn;
    c = s;
    while (c < H) begin
      a  = (d == 0) ? c : nth_tick_after(c, d);
      dn = (w == 0) ? a : nth_tick_after(a, w);
      for (int k = c; k <= dn && k < H; k++) e_busy[k] = 1'b1;
      for (int k = a; k < dn && k < H; k++) e_pulse[k] = 1'b1;
      if (dn < H) e_done[dn] = 1'b1;
      if (!rep) break;
      c = dn + 1;
    end
  endtask

  task automatic build_expect();
    for (int k = 0; k < H; k++) begin
      e_pulse[k] = 1'b0; e_busy[k] = 1'b0; e_done[k] = 1'b0;
    end
    for (int k = 0; k < H; k++) begin
      if (s_rst[k] || s_stop[k]) begin
        for (int j = k; j < H; j++) begin
          e_pulse[j] = 1'b0; e_busy[j] = 1'b0; e_done[j] = 1'b0;
        end
      end else if (s_start[k] && (k == 0 || !e_busy[k-1])) begin
        plan(k, s_d[k], s_w[k], s_rep[k] && REP_BUILT);
      end
    end
  endtask

  task automatic step(input int k);
    rst_n       = ~s_rst[k];
    ps_tick     = s_tick[k];
    start       = s_start[k];
    stop        = s_stop[k];
    repeat_mode = s_rep[k];
    delay_count = W'(s_d[k]);
    width_count = W'(s_w[k]);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_scn();
    s_rst[1] = 1'b1; s_start[0] = 1'b1; s_start[1] = 1'b1; s_tick[0] = 1'b1; s_tick[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(k);
      n_checks++;
      if ({pulse_out, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset cyc %0d: pulse/busy/done=%b%b%b expected 000", k, pulse_out, busy, done);
      end
    end
  endtask

  task automatic test_oneshot_d3w2();
    int dones = 0;
    clear_scn();
    for (int k = 0; k < H; k++) s_tick[k] = (k % 4 == 0);
    s_start[3] = 1'b1; s_d[3] = 3; s_w[3] = 2; s_rep[3] = 1'b0;
    build_expect();
    for (int k = 0; k < H; k++) begin
      step(k);
      dones += int'(done);
      n_checks++;
      if ({pulse_out, busy, done} !== {e_pulse[k], e_busy[k], e_done[k]}) begin
        n_fail++;
        $display("FAIL oneshot_d3w2 cyc %0d: pulse/busy/done=%b%b%b expected %b%b%b",
                 k, pulse_out, busy, done, e_pulse[k], e_busy[k], e_done[k]);
      end
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL oneshot_d3w2 done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_zero_delay(input int w);
    clear_scn();
    for (int k = 0; k < H; k++) s_tick[k] = 1'b1;
    s_start[2] = 1'b1; s_d[2] = 0; s_w[2] = w; s_rep[2] = 1'b0;
    build_expect();
    for (int k = 0; k < H; k++) begin
      step(k);
      n_checks++;
      if ({pulse_out, busy, done} !== {e_pulse[k], e_busy[k], e_done[k]}) begin
        n_fail++;
        $display("FAIL zero_delay_w%0d cyc %0d: pulse/busy/done=%b%b%b expected %b%b%b",
                 w, k, pulse_out, busy, done, e_pulse[k], e_busy[k], e_done[k]);
      end
      // Direct timing anchor: start sampled at edge 2.
      if (k == 2 || k == 3) begin
        n_checks++;
        if (done !== ((w == 0) ? (k == 2) : (k == 3))) begin
          n_fail++;
          $display("FAIL zero_delay_w%0d done_edge cyc %0d: got %b", w, k, done);
        end
      end
    end
  endtask

  task automatic test_periodic_stop();
    int dones = 0;
    clear_scn();
    for (int k = 0; k < H; k++) s_tick[k] = 1'b1;
    s_start[2] = 1'b1; s_d[2] = 2; s_w[2] = 2; s_rep[2] = 1'b1;
    s_stop[60] = 1'b1;
    build_expect();
    for (int k = 0; k < H; k++) begin
      step(k);
      dones += int'(done);
      n_checks++;
      if ({pulse_out, busy, done} !== {e_pulse[k], e_busy[k], e_done[k]}) begin
        n_fail++;
        $display("FAIL periodic_stop cyc %0d: pulse/busy/done=%b%b%b expected %b%b%b",
                 k, pulse_out, busy, done, e_pulse[k], e_busy[k], e_done[k]);
      end
    end
    // Done at edges 6, 11, ..., 56 when periodic; a single done otherwise.
    n_checks++;
    if (dones !== (REP_BUILT ? 11 : 1)) begin
      n_fail++;
      $display("FAIL periodic_stop done_count: got %0d expected %0d", dones, REP_BUILT ? 11 : 1);
    end
  endtask

  task automatic test_start_while_busy();
    clear_scn();
    for (int k = 0; k < H; k++) s_tick[k] = 1'($urandom_range(1));
    s_start[2] = 1'b1; s_d[2] = 4; s_w[2] = 3; s_rep[2] = 1'b0;
    s_start[5] = 1'b1; s_start[9] = 1'b1; s_start[14] = 1'b1;
    s_start[110] = 1'b1; s_stop[110] = 1'b1; s_d[110] = 0; s_w[110] = 3;
    build_expect();
    for (int k = 0; k < H; k++) begin
      step(k);
      n_checks++;
      if ({pulse_out, busy, done} !== {e_pulse[k], e_busy[k], e_done[k]}) begin
        n_fail++;
        $display("FAIL start_while_busy cyc %0d: pulse/busy/done=%b%b%b expected %b%b%b",
                 k, pulse_out, busy, done, e_pulse[k], e_busy[k], e_done[k]);
      end
    end
  endtask

  task automatic test_reset_mid_active();
    clear_scn();
    for (int k = 0; k < H; k++) s_tick[k] = 1'b1;
    s_start[2]  = 1'b1; s_d[2]  = 1; s_w[2]  = 20; s_rep[2]  = 1'b0;
    s_rst[10]   = 1'b1;
    s_start[15] = 1'b1; s_d[15] = 2; s_w[15] = 3;  s_rep[15] = 1'b0;
    build_expect();
    for (int k = 0; k < H; k++) begin
      step(k);
      n_checks++;
      if ({pulse_out, busy, done} !== {e_pulse[k], e_busy[k], e_done[k]}) begin
        n_fail++;
        $display("FAIL reset_mid_active cyc %0d: pulse/busy/done=%b%b%b expected %b%b%b",
                 k, pulse_out, busy, done, e_pulse[k], e_busy[k], e_done[k]);
      end
    end
  endtask

  task automatic test_random(input int iter);
    int pct;
    clear_scn();
    pct = int'($urandom_range(100, 20));
    for (int k = 0; k < H; k++) begin
      s_tick[k]  = (int'($urandom_range(99)) < pct);
      s_start[k] = ($urandom_range(7) == 0);
      s_stop[k]  = (k > 0) && ($urandom_range(39) == 0);
      s_d[k]     = int'($urandom_range(6));
      s_w[k]     = int'($urandom_range(6));
    end
    build_expect();
    for (int k = 0; k < H; k++) begin
      step(k);
      n_checks++;
      if ({pulse_out, busy, done} !== {e_pulse[k], e_busy[k], e_done[k]}) begin
        n_fail++;
        $display("FAIL random%0d cyc %0d: pulse/busy/done=%b%b%b expected %b%b%b",
                 iter, k, pulse_out, busy, done, e_pulse[k], e_busy[k], e_done[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot_d3w2();
    test_zero_delay(1);
    test_zero_delay(0);
    test_periodic_stop();
    test_start_while_busy();
    test_reset_mid_active();
    for (int i = 0; i < 20; i++) test_random(i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
